// File: rtl/mem_arbiter.sv
// Memory arbiter: shares one byte-wide RAM port between instruction fetch and load/store.
// Transfers are sequenced one byte per cycle. A completed transfer produces a one-cycle done
// pulse followed by a DONE cycle, which gives the requester time to drop its request.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        clear,
    input  logic        if_sig,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_sig,
    input  logic        ls_load_or_store,
    input  logic [2:0]  ls_len,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_store_val,
    output logic        ls_done,
    output logic [31:0] ls_data
);

    typedef enum logic [2:0] {
        StIdle,
        StIfRead,
        StLsRead,
        StLsWrite,
        StDone
    } state_e;

    // UART-mapped window; stores here must wait while the output buffer is full
    localparam logic [31:0] IoLo = 32'h0003_0000;
    localparam logic [31:0] IoHi = 32'h0003_0007;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;       // index of the byte currently in flight
    logic [1:0]  last_q, last_d;     // index of the final byte (n - 1)
    logic [31:0] addr_q, addr_d;
    logic [31:0] wval_q, wval_d;
    logic [31:0] buf_q, buf_d;       // read bytes assembled so far, upper bytes zero
    logic        rr_ls_q, rr_ls_d;   // 1: load/store won the most recent grant
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic        if_done_q, if_done_d;
    logic        ls_done_q, ls_done_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] ls_data_q, ls_data_d;

    logic        ls_is_io;
    logic        ls_blocked;
    logic        ls_req;
    logic        grant_ls;
    logic        grant_if;
    logic [1:0]  ls_last;
    logic [31:0] next_addr;

    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign mem_wr   = mem_wr_q;
    assign if_done  = if_done_q;
    assign if_data  = if_data_q;
    assign ls_done  = ls_done_q;
    assign ls_data  = ls_data_q;

    assign ls_is_io   = (ls_addr >= IoLo) && (ls_addr <= IoHi);
    assign ls_blocked = ls_load_or_store && ls_is_io && io_buffer_full;
    assign ls_req     = ls_sig && !ls_blocked;

    // Address of the byte after the current one; wraps modulo 2^32
    assign next_addr = addr_q + {30'd0, cnt_q} + 32'd1;

    // Round-robin arbitration: on a conflict, grant whoever did not win last time
    always_comb begin
        grant_ls = ls_req && (!if_sig || !rr_ls_q);
        grant_if = if_sig && !grant_ls;
    end

    // Decode access length into final byte index; unsupported lengths act as a word
    always_comb begin
        case (ls_len)
            3'd1:    ls_last = 2'd0;
            3'd2:    ls_last = 2'd1;
            default: ls_last = 2'd3;
        endcase
    end

    // Next-state and output sequencing
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        addr_d     = addr_q;
        wval_d     = wval_q;
        buf_d      = buf_q;
        rr_ls_d    = rr_ls_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        if_data_d  = if_data_q;
        ls_data_d  = ls_data_q;
        if_done_d  = 1'b0;
        ls_done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A flush in IDLE suppresses any grant on this edge
                if (!clear) begin
                    if (grant_ls) begin
                        rr_ls_d = 1'b1;
                        addr_d  = ls_addr;
                        last_d  = ls_last;
                        cnt_d   = 2'd0;
                        buf_d   = 32'd0;
                        mem_a_d = ls_addr;
                        if (ls_load_or_store) begin
                            state_d    = StLsWrite;
                            wval_d     = ls_store_val;
                            mem_wr_d   = 1'b1;
                            mem_dout_d = ls_store_val[7:0];
                        end else begin
                            state_d  = StLsRead;
                            mem_wr_d = 1'b0;
                        end
                    end else if (grant_if) begin
                        rr_ls_d  = 1'b0;
                        addr_d   = if_addr;
                        last_d   = 2'd3;
                        cnt_d    = 2'd0;
                        buf_d    = 32'd0;
                        mem_a_d  = if_addr;
                        mem_wr_d = 1'b0;
                        state_d  = StIfRead;
                    end
                end
            end

            StIfRead, StLsRead: begin
                if (clear) begin
                    // Abort a speculative read: no done, result registers untouched
                    state_d = StIdle;
                    cnt_d   = 2'd0;
                end else begin
                    buf_d[{cnt_q, 3'b000} +: 8] = mem_din;
                    mem_a_d = next_addr;
                    if (cnt_q == last_q) begin
                        cnt_d   = 2'd0;
                        state_d = StDone;
                        if (state_q == StIfRead) begin
                            if_data_d = buf_d;
                            if_done_d = 1'b1;
                        end else begin
                            ls_data_d = buf_d;
                            ls_done_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end

            StLsWrite: begin
                // Committed stores run to completion regardless of clear
                if (cnt_q == last_q) begin
                    mem_wr_d  = 1'b0;
                    ls_done_d = 1'b1;
                    cnt_d     = 2'd0;
                    state_d   = StDone;
                end else begin
                    cnt_d      = cnt_q + 2'd1;
                    mem_a_d    = next_addr;
                    mem_dout_d = wval_q[{cnt_d, 3'b000} +: 8];
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d  = StIdle;
                mem_wr_d = 1'b0;
            end
        endcase
    end

    // State register: rst wins over everything, rdy low freezes the whole block
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 2'd0;
            last_q     <= 2'd0;
            addr_q     <= 32'd0;
            wval_q     <= 32'd0;
            buf_q      <= 32'd0;
            rr_ls_q    <= 1'b0;
            mem_a_q    <= 32'd0;
            mem_dout_q <= 8'd0;
            mem_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_data_q  <= 32'd0;
            ls_data_q  <= 32'd0;
        end else if (rdy) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            wval_q     <= wval_d;
            buf_q      <= buf_d;
            rr_ls_q    <= rr_ls_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            if_data_q  <= if_data_d;
            ls_data_q  <= ls_data_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a byte RAM model behind the arbiter port, cycle-exact
// expectations written out by hand. Inputs are driven and outputs sampled on the falling edge.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;
    logic        clear;
    logic        if_sig;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_sig;
    logic        ls_load_or_store;
    logic [2:0]  ls_len;
    logic [31:0] ls_addr;
    logic [31:0] ls_store_val;
    logic        ls_done;
    logic [31:0] ls_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Preloaded contents plus an overlay of bytes written by the DUT (4 KiB, address aliased)
    logic [7:0] rom  [0:4095];
    logic [7:0] wmem [0:4095];
    logic       wv   [0:4095];

    // Length table for plain loads from 0x200 (RAM bytes 78 56 34 12)
    logic [2:0]  ld_len  [4] = '{3'd2, 3'd4, 3'd1, 3'd6};
    int          ld_cyc  [4] = '{3, 5, 2, 5};
    logic [31:0] ld_data [4] = '{32'h0000_5678, 32'h1234_5678, 32'h0000_0078, 32'h1234_5678};

    logic [31:0] sw_val;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .mem_din          (mem_din),
        .mem_dout         (mem_dout),
        .mem_a            (mem_a),
        .mem_wr           (mem_wr),
        .io_buffer_full   (io_buffer_full),
        .clear            (clear),
        .if_sig           (if_sig),
        .if_addr          (if_addr),
        .if_done          (if_done),
        .if_data          (if_data),
        .ls_sig           (ls_sig),
        .ls_load_or_store (ls_load_or_store),
        .ls_len           (ls_len),
        .ls_addr          (ls_addr),
        .ls_store_val     (ls_store_val),
        .ls_done          (ls_done),
        .ls_data          (ls_data)
    );

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return wv[a[11:0]] ? wmem[a[11:0]] : rom[a[11:0]];
    endfunction

    always_comb mem_din = ram_rd(mem_a);

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4096; i++) wv[i] <= 1'b0;
        end else if (mem_wr) begin
            wmem[mem_a[11:0]] <= mem_dout;
            wv[mem_a[11:0]]   <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
        if_sig = 1'b0; if_addr = '0;
        ls_sig = 1'b0; ls_load_or_store = 1'b0; ls_len = '0; ls_addr = '0; ls_store_val = '0;
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        rom[12'h100] = 8'h13;
        rom[12'h010] = 8'hA5;
        rom[12'h200] = 8'h78; rom[12'h201] = 8'h56; rom[12'h202] = 8'h34; rom[12'h203] = 8'h12;
        rom[12'h206] = 8'h11; rom[12'h207] = 8'h22;
        rom[12'hFFE] = 8'h11; rom[12'hFFF] = 8'h22; rom[12'h000] = 8'h33; rom[12'h001] = 8'h44;

        cyc(); cyc();
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_dout", mem_dout, 0);
        check("rst_if_done", if_done, 0);
        check("rst_ls_done", ls_done, 0);
        check("rst_if_data", if_data, 0);
        check("rst_ls_data", ls_data, 0);
        rst = 1'b0;

        // Fetch of 0x100: four consecutive addresses, done in the 5th cycle after grant
        if_sig = 1'b1; if_addr = 32'h100;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            check("fetch_done", if_done, k == 5);
            check("fetch_wr", mem_wr, 0);
            if (k <= 4) check("fetch_a", mem_a, 32'h100 + k - 1);
        end
        check("fetch_data", if_data, 32'h0000_0013);
        if_sig = 1'b0;
        cyc();
        check("fetch_done_pulse", if_done, 0);

        // SH of 0xDEADBEEF to 0x204
        ls_sig = 1'b1; ls_load_or_store = 1'b1; ls_len = 3'd2;
        ls_addr = 32'h204; ls_store_val = 32'hDEAD_BEEF;
        cyc();
        check("sh_wr0", mem_wr, 1); check("sh_a0", mem_a, 32'h204); check("sh_d0", mem_dout, 8'hEF);
        check("sh_done0", ls_done, 0);
        cyc();
        check("sh_wr1", mem_wr, 1); check("sh_a1", mem_a, 32'h205); check("sh_d1", mem_dout, 8'hBE);
        cyc();
        check("sh_wr_end", mem_wr, 0); check("sh_done", ls_done, 1);
        ls_sig = 1'b0;
        check("sh_ram204", ram_rd(32'h204), 8'hEF);
        check("sh_ram205", ram_rd(32'h205), 8'hBE);
        check("sh_ram206", ram_rd(32'h206), 8'h11);
        check("sh_ram207", ram_rd(32'h207), 8'h22);
        cyc();
        check("sh_done_pulse", ls_done, 0);

        // Loads of each length from 0x200
        for (int t = 0; t < 4; t++) begin
            ls_sig = 1'b1; ls_load_or_store = 1'b0; ls_len = ld_len[t]; ls_addr = 32'h200;
            for (int k = 1; k <= ld_cyc[t]; k++) begin
                cyc();
                check("ld_done", ls_done, k == ld_cyc[t]);
            end
            check("ld_data", ls_data, ld_data[t]);
            ls_sig = 1'b0;
            cyc();
        end

        // Fetch across the top of the address space
        if_sig = 1'b1; if_addr = 32'hFFFF_FFFE;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            if (k <= 4) check("wrap_a", mem_a, 32'hFFFF_FFFE + (k - 1));
            check("wrap_done", if_done, k == 5);
        end
        check("wrap_data", if_data, 32'h4433_2211);
        if_sig = 1'b0;
        cyc();

        // Flush on the 2nd fetch byte, then a flush in IDLE holds off the next grant
        if_sig = 1'b1; if_addr = 32'h100;
        cyc(); check("fl_a1", mem_a, 32'h100);
        cyc(); check("fl_a2", mem_a, 32'h101);
        clear = 1'b1; if_addr = 32'h200;
        cyc();
        check("fl_abort_a", mem_a, 32'h101); check("fl_abort_done", if_done, 0);
        check("fl_abort_wr", mem_wr, 0); check("fl_abort_data", if_data, 32'h4433_2211);
        cyc();
        check("fl_idle_hold_a", mem_a, 32'h101);
        clear = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            check("fl_refetch_done", if_done, k == 5);
            check("fl_refetch_wr", mem_wr, 0);
        end
        check("fl_refetch_data", if_data, 32'h1234_5678);
        if_sig = 1'b0;
        cyc();

        // Flush on the final fetch byte suppresses the done
        if_sig = 1'b1; if_addr = 32'h100;
        for (int k = 1; k <= 4; k++) cyc();
        clear = 1'b1;
        cyc();
        check("fl_last_done", if_done, 0);
        check("fl_last_data", if_data, 32'h1234_5678);
        clear = 1'b0; if_sig = 1'b0;
        cyc();

        // SW with clear held high throughout: all four bytes still written
        sw_val = 32'hCAFE_F00D;
        ls_sig = 1'b1; ls_load_or_store = 1'b1; ls_len = 3'd4; ls_addr = 32'h300;
        ls_store_val = sw_val;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            if (k == 1) clear = 1'b1;
            check("sw_wr", mem_wr, k <= 4);
            check("sw_done", ls_done, k == 5);
            if (k <= 4) begin
                check("sw_a", mem_a, 32'h300 + k - 1);
                check("sw_d", mem_dout, (sw_val >> (8 * (k - 1))) & 32'hFF);
            end
        end
        clear = 1'b0; ls_sig = 1'b0;
        check("sw_ram300", ram_rd(32'h300), 8'h0D);
        check("sw_ram301", ram_rd(32'h301), 8'hF0);
        check("sw_ram302", ram_rd(32'h302), 8'hFE);
        check("sw_ram303", ram_rd(32'h303), 8'hCA);
        cyc();

        // SB to the UART window while its buffer is full; a fetch slips past
        io_buffer_full = 1'b1;
        ls_sig = 1'b1; ls_load_or_store = 1'b1; ls_len = 3'd1; ls_addr = 32'h3_0000;
        ls_store_val = 32'h0000_005A;
        if_sig = 1'b1; if_addr = 32'h100;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            check("io_wr_blocked", mem_wr, 0);
            check("io_if_done", if_done, k == 5);
            if (k == 5) if_sig = 1'b0;
        end
        io_buffer_full = 1'b0;
        cyc();
        check("io_wr", mem_wr, 1); check("io_a", mem_a, 32'h3_0000); check("io_d", mem_dout, 8'h5A);
        cyc();
        check("io_wr_end", mem_wr, 0); check("io_done", ls_done, 1);
        check("io_ram", ram_rd(32'h3_0000), 8'h5A);
        ls_sig = 1'b0;
        cyc();

        // LW stalled by rdy low for three edges mid-transfer
        ls_sig = 1'b1; ls_load_or_store = 1'b0; ls_len = 3'd4; ls_addr = 32'h200;
        cyc(); check("st_a1", mem_a, 32'h200);
        cyc(); check("st_a2", mem_a, 32'h201);
        rdy = 1'b0;
        for (int k = 3; k <= 8; k++) begin
            cyc();
            if (k <= 5) check("st_frozen_a", mem_a, 32'h201);
            else if (k <= 7) check("st_a", mem_a, 32'h200 + k - 4);
            check("st_done", ls_done, k == 8);
            if (k == 5) rdy = 1'b1;
        end
        check("st_data", ls_data, 32'h1234_5678);
        rdy = 1'b0;
        cyc();
        check("st_done_held", ls_done, 1);
        rdy = 1'b1; ls_sig = 1'b0;
        cyc();
        check("st_done_released", ls_done, 0);

        // Reset mid-SW overrides rdy low and clear
        ls_sig = 1'b1; ls_load_or_store = 1'b1; ls_len = 3'd4; ls_addr = 32'h400;
        ls_store_val = 32'h1122_3344;
        cyc(); check("rw_wr", mem_wr, 1);
        cyc();
        rst = 1'b1; rdy = 1'b0; clear = 1'b1;
        cyc();
        check("rw_wr_off", mem_wr, 0); check("rw_a", mem_a, 32'h0);
        check("rw_ls_data", ls_data, 0); check("rw_if_data", if_data, 0);
        check("rw_ls_done", ls_done, 0);
        rst = 1'b0; rdy = 1'b1; clear = 1'b0;

        // Conflict straight out of reset: LS (LB 0x10) first, then fetch, then LS waits
        if_sig = 1'b1; if_addr = 32'h100;
        ls_sig = 1'b1; ls_load_or_store = 1'b0; ls_len = 3'd1; ls_addr = 32'h10;
        cyc(); check("cf_ls_first", mem_a, 32'h10);
        cyc();
        check("cf_ls_done", ls_done, 1); check("cf_ls_data", ls_data, 32'h0000_00A5);
        check("cf_if_wait", if_done, 0);
        ls_sig = 1'b0;
        cyc();
        check("cf_done_no_grant", mem_a, 32'h11);
        ls_sig = 1'b1;
        cyc(); check("cf_fetch_next", mem_a, 32'h100);
        for (int k = 2; k <= 5; k++) begin
            cyc();
            check("cf_if_done", if_done, k == 5);
            check("cf_ls_idle", ls_done, 0);
        end
        check("cf_if_data", if_data, 32'h0000_0013);
        if_sig = 1'b0;
        cyc();
        cyc(); check("cf_ls_second", mem_a, 32'h10);
        cyc();
        check("cf_ls_done2", ls_done, 1); check("cf_ls_data2", ls_data, 32'h0000_00A5);
        ls_sig = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
